// File: rtl/oscillation_monitor_v2.sv
// Oscillation monitor: tracks the sign of a position error with a deadband,
// counts sign reversals over fixed windows of enabled samples, and raises a
// flag when a window holds enough reversals. The flag drops only after a run
// of consecutive quiet windows. Peak |error| per window is reported as well.
module oscillation_monitor_v2 #(
  parameter int DATA_W        = 32,
  parameter int WINDOW_LEN    = 100,
  parameter int CNT_W         = 8,
  parameter int MIN_CROSSINGS = 4,
  parameter int DEADBAND      = 10,
  parameter int CLEAR_WINDOWS = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sample_en,
  input  logic signed [DATA_W-1:0] error_in,
  input  logic                     clr,
  output logic                     oscillating_flag,
  output logic [CNT_W-1:0]         crossing_count,
  output logic [DATA_W-1:0]        peak_abs,
  output logic                     window_done
);

  // Window index width; WINDOW_LEN is at least 2 so this is never zero.
  localparam int IDX_W = $clog2(WINDOW_LEN);
  // Quiet counter must be able to hold CLEAR_WINDOWS itself.
  localparam int Q_W   = $clog2(CLEAR_WINDOWS + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(WINDOW_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]    MIN_CROSS    = (CNT_W + 1)'(MIN_CROSSINGS);
  localparam logic [Q_W-1:0]    QUIET_TARGET = Q_W'(CLEAR_WINDOWS);
  localparam logic [DATA_W-1:0] ABS_MAX      = {1'b0, {(DATA_W - 1){1'b1}}};

  // Deadband thresholds carried one bit wider than the data so that neither
  // -DEADBAND nor the extreme error values can overflow in the comparison.
  localparam logic signed [DATA_W:0] DB_POS = (DATA_W + 1)'(DEADBAND);
  localparam logic signed [DATA_W:0] DB_NEG = -DB_POS;

  typedef enum logic [1:0] {
    TRK_NONE = 2'd0,
    TRK_POS  = 2'd1,
    TRK_NEG  = 2'd2
  } trk_t;

  // State registers
  trk_t              r_trk;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_peak;
  logic [Q_W-1:0]    r_quiet;
  logic              r_flag;
  logic              r_done;
  logic [CNT_W-1:0]  r_cross_out;
  logic [DATA_W-1:0] r_peak_out;

  // Per-sample combinational results
  logic signed [DATA_W:0] w_err_ext;
  logic                   w_above;
  logic                   w_below;
  trk_t                   w_trk_next;
  logic                   w_crossing;
  logic [DATA_W-1:0]      w_abs;
  logic [CNT_W-1:0]       w_cnt_sum;
  logic [DATA_W-1:0]      w_peak_sum;
  logic                   w_last;
  logic                   w_close;
  logic                   w_count_hit;
  logic [Q_W-1:0]         w_quiet_inc;
  logic                   w_quiet_done;

  assign w_err_ext = {error_in[DATA_W-1], error_in};
  assign w_above   = (w_err_ext > DB_POS);
  assign w_below   = (w_err_ext < DB_NEG);

  // Next tracker state: only samples clearly outside the deadband move it.
  always_comb begin
    w_trk_next = r_trk;
    if (w_above) begin
      w_trk_next = TRK_POS;
    end else if (w_below) begin
      w_trk_next = TRK_NEG;
    end
  end

  // Only a reversal between two known signs is a crossing; leaving NONE is not.
  assign w_crossing = ((r_trk == TRK_POS) && (w_trk_next == TRK_NEG)) ||
                      ((r_trk == TRK_NEG) && (w_trk_next == TRK_POS));

  // Magnitude with the most-negative value clamped to the largest positive.
  always_comb begin
    w_abs = $unsigned(error_in);
    if (error_in[DATA_W-1]) begin
      if (error_in[DATA_W-2:0] == '0) begin
        w_abs = ABS_MAX;
      end else begin
        w_abs = $unsigned(-error_in);
      end
    end
  end

  // Running values including the current sample (used both to accumulate
  // and to publish the window result on the closing sample).
  assign w_cnt_sum  = (w_crossing && (r_cnt != CNT_MAX)) ? r_cnt + 1'b1 : r_cnt;
  assign w_peak_sum = (w_abs > r_peak) ? w_abs : r_peak;

  assign w_last  = (r_idx == LAST_IDX);
  assign w_close = sample_en && w_last && !clr;

  assign w_count_hit  = ({1'b0, w_cnt_sum} >= MIN_CROSS);
  assign w_quiet_inc  = (r_quiet >= QUIET_TARGET) ? QUIET_TARGET : r_quiet + 1'b1;
  assign w_quiet_done = (w_quiet_inc >= QUIET_TARGET);

  // Sign tracker: advances on enabled samples, forced to NONE by clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_trk <= TRK_NONE;
    end else if (clr) begin
      r_trk <= TRK_NONE;
    end else if (sample_en) begin
      r_trk <= w_trk_next;
    end
  end

  // Window position: counts enabled samples and wraps after the last one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx <= '0;
    end else if (clr) begin
      r_idx <= '0;
    end else if (sample_en) begin
      r_idx <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  // Running crossing count and peak for the window in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_peak <= '0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_peak <= '0;
    end else if (sample_en) begin
      if (w_last) begin
        r_cnt  <= '0;
        r_peak <= '0;
      end else begin
        r_cnt  <= w_cnt_sum;
        r_peak <= w_peak_sum;
      end
    end
  end

  // Published window results; clr deliberately leaves them untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cross_out <= '0;
      r_peak_out  <= '0;
    end else if (w_close) begin
      r_cross_out <= w_cnt_sum;
      r_peak_out  <= w_peak_sum;
    end
  end

  // Flag with hysteresis: set by one busy window, cleared by a quiet run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flag  <= 1'b0;
      r_quiet <= '0;
    end else if (clr) begin
      r_flag  <= 1'b0;
      r_quiet <= '0;
    end else if (w_close) begin
      if (w_count_hit) begin
        r_flag  <= 1'b1;
        r_quiet <= '0;
      end else begin
        r_quiet <= w_quiet_inc;
        if (w_quiet_done) begin
          r_flag <= 1'b0;
        end
      end
    end
  end

  // Window-complete strobe: high for the single clock after the closing edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_close;
    end
  end

  assign oscillating_flag = r_flag;
  assign crossing_count   = r_cross_out;
  assign peak_abs         = r_peak_out;
  assign window_done      = r_done;

endmodule

// File: tb/tb_oscillation_monitor_v2.sv
// Bench for oscillation_monitor_v2: directed scenarios plus randomized windows,
// all checked against a window-level reference model (sample queue per window).
module tb_oscillation_monitor_v2;

  localparam int DATA_W        = 32;
  localparam int WINDOW_LEN    = 100;
  localparam int CNT_W         = 8;
  localparam int MIN_CROSSINGS = 4;
  localparam int DEADBAND      = 10;
  localparam int CLEAR_WINDOWS = 2;
  localparam longint ABS_LIMIT = 64'sd2147483647;
  localparam int NEG_MIN       = int'(32'h8000_0000);

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     sample_en;
  logic signed [DATA_W-1:0] error_in;
  logic                     clr;
  logic                     oscillating_flag;
  logic [CNT_W-1:0]         crossing_count;
  logic [DATA_W-1:0]        peak_abs;
  logic                     window_done;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  longint m_q[$];
  int     m_start_sign;
  int     m_quiet;
  int     m_flag;
  int     m_cc;
  longint m_peak;
  int     m_done;
  int     m_windows;

  always #5 clk = ~clk;

  oscillation_monitor_v2 #(
    .DATA_W       (DATA_W),
    .WINDOW_LEN   (WINDOW_LEN),
    .CNT_W        (CNT_W),
    .MIN_CROSSINGS(MIN_CROSSINGS),
    .DEADBAND     (DEADBAND),
    .CLEAR_WINDOWS(CLEAR_WINDOWS)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sample_en       (sample_en),
    .error_in        (error_in),
    .clr             (clr),
    .oscillating_flag(oscillating_flag),
    .crossing_count  (crossing_count),
    .peak_abs        (peak_abs),
    .window_done     (window_done)
  );

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_start_sign = 0;
    m_quiet      = 0;
    m_flag       = 0;
    m_cc         = 0;
    m_peak       = 0;
    m_done       = 0;
  endtask

  // Evaluate a complete window from its sample list.
  task automatic model_close();
    int     s;
    int     ns;
    int     x;
    longint a;
    longint pk;
    s  = m_start_sign;
    x  = 0;
    pk = 0;
    foreach (m_q[k]) begin
      ns = s;
      if (m_q[k] > DEADBAND) ns = 1;
      else if (m_q[k] < -DEADBAND) ns = -1;
      if (s != 0 && ns == -s) x++;
      s = ns;
      a = (m_q[k] < 0) ? -m_q[k] : m_q[k];
      if (a > ABS_LIMIT) a = ABS_LIMIT;
      if (a > pk) pk = a;
    end
    if (x > (1 << CNT_W) - 1) x = (1 << CNT_W) - 1;
    m_cc         = x;
    m_peak       = pk;
    m_done       = 1;
    m_start_sign = s;
    m_q.delete();
    if (x >= MIN_CROSSINGS) begin
      m_flag  = 1;
      m_quiet = 0;
    end else begin
      m_quiet = (m_quiet + 1 > CLEAR_WINDOWS) ? CLEAR_WINDOWS : m_quiet + 1;
      if (m_quiet == CLEAR_WINDOWS) m_flag = 0;
    end
  endtask

  task automatic model_update(input bit en, input int val, input bit c);
    m_done = 0;
    if (c) begin
      m_q.delete();
      m_start_sign = 0;
      m_quiet      = 0;
      m_flag       = 0;
    end else if (en) begin
      m_q.push_back(longint'(val));
      if (m_q.size() == WINDOW_LEN) model_close();
    end
  endtask

  // One clock: drive, clock, then compare every output with the model.
  task automatic step(input bit en, input int val, input bit c);
    sample_en = en;
    error_in  = val;
    clr       = c;
    @(posedge clk);
    #1;
    model_update(en, val, c);
    check_value("done", {63'd0, window_done}, 64'(m_done));
    check_value("flag", {63'd0, oscillating_flag}, 64'(m_flag));
    check_value("cc", 64'(crossing_count), 64'(m_cc));
    check_value("peak", 64'(peak_abs), 64'(m_peak));
    if (m_done != 0) begin
      m_windows++;
      $display("[TB] window %0d closed: crossings=%0d peak=%0d flag=%0d",
               m_windows, crossing_count, peak_abs, oscillating_flag);
    end
    sample_en = 1'b0;
    clr       = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int early;
    int v;
    int period;
    int amp;
    int mode;
    int n;

    m_windows = 0;
    model_reset();
    reset_n   = 1'b0;
    sample_en = 1'b0;
    error_in  = '0;
    clr       = 1'b0;
    #22;
    check_value("rst_flag", {63'd0, oscillating_flag}, 64'd0);
    check_value("rst_done", {63'd0, window_done}, 64'd0);
    check_value("rst_cc", 64'(crossing_count), 64'd0);
    check_value("rst_peak", 64'(peak_abs), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Alternating inside the deadband: no crossings, flag stays low.
    for (int i = 0; i < WINDOW_LEN; i++) step(1'b1, (i % 2 != 0) ? -8 : 8, 1'b0);
    check_value("db_done", {63'd0, window_done}, 64'd1);
    check_value("db_cc", 64'(crossing_count), 64'd0);
    check_value("db_flag", {63'd0, oscillating_flag}, 64'd0);

    // +50/-50 blocks of 10: nine reversals, flag set.
    for (int i = 0; i < WINDOW_LEN; i++) step(1'b1, ((i / 10) % 2 != 0) ? -50 : 50, 1'b0);
    check_value("osc_done", {63'd0, window_done}, 64'd1);
    check_value("osc_cc", 64'(crossing_count), 64'd9);
    check_value("osc_peak", 64'(peak_abs), 64'd50);
    check_value("osc_flag", {63'd0, oscillating_flag}, 64'd1);

    // Constant +30: flag survives one quiet window, drops after the second.
    for (int i = 0; i < WINDOW_LEN; i++) step(1'b1, 30, 1'b0);
    check_value("quiet1_flag", {63'd0, oscillating_flag}, 64'd1);
    check_value("quiet1_cc", 64'(crossing_count), 64'd1);
    for (int i = 0; i < WINDOW_LEN; i++) step(1'b1, 30, 1'b0);
    check_value("quiet2_flag", {63'd0, oscillating_flag}, 64'd0);

    // Most-negative input saturates; idle clocks carry junk that must be ignored.
    for (int i = 0; i < WINDOW_LEN; i++) begin
      step(1'b1, (i == 37) ? NEG_MIN : 0, 1'b0);
      if (i != WINDOW_LEN - 1) step(1'b0, 1000, 1'b0);
    end
    check_value("negmin_peak", 64'(peak_abs), 64'd2147483647);
    check_value("negmin_done", {63'd0, window_done}, 64'd1);

    // Raise the flag, then clr at sample 57 together with a discarded sample.
    for (int i = 0; i < WINDOW_LEN; i++) step(1'b1, ((i / 10) % 2 != 0) ? -50 : 50, 1'b0);
    check_value("pre_clr_flag", {63'd0, oscillating_flag}, 64'd1);
    for (int i = 0; i < 56; i++) step(1'b1, 50, 1'b0);
    step(1'b1, -500, 1'b1);
    check_value("clr_flag", {63'd0, oscillating_flag}, 64'd0);
    check_value("clr_cc_held", 64'(crossing_count), 64'd10);
    early = 0;
    for (int i = 1; i <= WINDOW_LEN; i++) begin
      step(1'b1, 20, 1'b0);
      if (i < WINDOW_LEN && window_done) early++;
    end
    check_value("clr_early_done", 64'(early), 64'd0);
    check_value("clr_done", {63'd0, window_done}, 64'd1);
    check_value("clr_peak", 64'(peak_abs), 64'd20);

    // Asynchronous reset mid-window.
    for (int i = 0; i < 40; i++) step(1'b1, ((i / 5) % 2 != 0) ? -70 : 70, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_value("arst_flag", {63'd0, oscillating_flag}, 64'd0);
    check_value("arst_done", {63'd0, window_done}, 64'd0);
    check_value("arst_cc", 64'(crossing_count), 64'd0);
    check_value("arst_peak", 64'(peak_abs), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    early = 0;
    for (int i = 1; i <= WINDOW_LEN; i++) begin
      step(1'b1, ((i / 7) % 2 != 0) ? -40 : 40, 1'b0);
      if (i < WINDOW_LEN && window_done) early++;
    end
    check_value("arst_early_done", 64'(early), 64'd0);
    check_value("arst_win_done", {63'd0, window_done}, 64'd1);

    // Randomized windows: oscillating or quiet, gaps in sample_en, rare clr.
    for (int w = 0; w < 24; w++) begin
      mode   = int'($urandom_range(0, 2));
      period = int'($urandom_range(3, 40));
      amp    = int'($urandom_range(5, 100000));
      n      = 0;
      for (int c = 0; c < 130; c++) begin
        if ($urandom_range(0, 49) == 0) begin
          v = ($urandom_range(0, 1) != 0) ? NEG_MIN : 32'h7FFF_FFFF;
        end else if (mode == 0) begin
          v = int'($urandom_range(0, 24)) - 12;
        end else begin
          v = (((n / period) % 2) != 0) ? -amp : amp;
          v = v + int'($urandom_range(0, 20)) - 10;
        end
        if ($urandom_range(0, 3) != 0) begin
          n++;
          step(1'b1, v, ($urandom_range(0, 399) == 0));
        end else begin
          step(1'b0, v, ($urandom_range(0, 399) == 0));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/oscillation_monitor_v2.md
OSCILLATION_MONITOR_V2 -- requirements
Module: oscillation_monitor_v2

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and reset_n.
REQ-002 Parameter DATA_W, default 32: width of the signed error input.
REQ-003 Parameter WINDOW_LEN, default 100: number of enabled samples per observation window, at least 2.
REQ-004 Parameter CNT_W, default 8: width of the crossing counter, with 2^CNT_W-1 >= WINDOW_LEN.
REQ-005 Parameter MIN_CROSSINGS, default 4: crossings per window needed to assert the flag.
REQ-006 Parameter DEADBAND, default 10: non-negative magnitude band about zero that is ignored for sign tracking.
REQ-007 Parameter CLEAR_WINDOWS, default 2: consecutive quiet windows needed to deassert the flag, at least 1.
REQ-008 Port clk, input, 1 bit: system clock, 100 MHz.
REQ-009 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-010 Port sample_en, input, 1 bit: single-cycle sample strobe (100 kHz tick).
REQ-011 Port error_in, input, DATA_W bits, signed: position error sample.
REQ-012 Port clr, input, 1 bit: synchronous restart of monitoring.
REQ-013 Port oscillating_flag, output, 1 bit, registered: oscillation detected.
REQ-014 Port crossing_count, output, CNT_W bits, registered: crossings in the last completed window.
REQ-015 Port peak_abs, output, DATA_W bits, registered, unsigned: peak |error| in the last completed window.
REQ-016 Port window_done, output, 1 bit, registered: one-clk pulse when a window completes.

Function
REQ-017 Internal state SHALL change only on a rising clk edge with sample_en=1, except for clr, reset_n and the window_done deassertion.
REQ-018 The sign tracker SHALL hold one of three states: NONE, POS or NEG.
- error_in > DEADBAND: tracker goes to POS.
- error_in < -DEADBAND: tracker goes to NEG.
- otherwise: tracker holds its state.
REQ-019 A crossing SHALL be counted only on a POS->NEG or NEG->POS transition; NONE->POS and NONE->NEG SHALL NOT count.
REQ-020 Comparisons SHALL use signed arithmetic, with no overflow at the most-negative or most-positive error_in.
REQ-021 The window counter SHALL run 0..WINDOW_LEN-1, incrementing once per enabled sample and wrapping to 0 after WINDOW_LEN-1.
REQ-022 The running crossing count SHALL saturate at 2^CNT_W-1.
REQ-023 |error_in| SHALL be computed per sample, with the most-negative value saturating to 2^(DATA_W-1)-1; the running peak SHALL keep the maximum.
REQ-024 On the sample at window index WINDOW_LEN-1, the window SHALL close on that same edge.
- The sample's own crossing and magnitude SHALL be included.
- crossing_count and peak_abs SHALL be loaded from the running values.
- The running count and running peak SHALL be zeroed.
- window_done SHALL pulse high for exactly one clk.
REQ-025 Flag set: at window close, if the final count >= MIN_CROSSINGS, oscillating_flag SHALL go to 1 and the quiet counter SHALL go to 0.
REQ-026 Flag clear: at window close with count < MIN_CROSSINGS, the quiet counter SHALL increment (saturating at CLEAR_WINDOWS); when it reaches CLEAR_WINDOWS, oscillating_flag SHALL go to 0.
REQ-027 The flag SHALL never change except at window close, clr or reset.
REQ-028 clr=1 SHALL, on that edge and regardless of sample_en:
- zero the window index, running count, running peak and quiet counter;
- set the tracker to NONE;
- deassert oscillating_flag and window_done;
- leave crossing_count and peak_abs holding their values.
REQ-029 When clr and sample_en are both high, clr SHALL win and the sample SHALL be discarded.
REQ-030 sample_en held high on consecutive clocks SHALL be processed as consecutive samples.

Reset
REQ-031 On reset_n=0, asynchronously and regardless of clk:
- oscillating_flag=0, window_done=0, crossing_count=0, peak_abs=0;
- window index, running count, running peak and quiet counter =0;
- tracker=NONE.
REQ-032 Reset asserted mid-window SHALL discard the partial window; the first full window SHALL start at the first sample_en after release.

Verification
REQ-033 With defaults, error alternating +50/-50 every 10 samples for 100 samples: window_done pulses once after the 100th sample, with crossing_count=9, peak_abs=50, flag=1.
REQ-034 With error alternating +8/-8 (inside the deadband) for 100 samples: crossing_count=0 and flag=0.
REQ-035 With flag=1, then constant +30 for 100 samples: flag stays 1 after that window and goes to 0 after the second quiet window (CLEAR_WINDOWS=2).
REQ-036 With error_in=-2^31 in one sample: peak_abs = 2147483647 at window close.
REQ-037 Pulse clr at sample 57 with flag=1: flag=0 on that edge, and the next window_done occurs 100 samples after clr.
REQ-038 Assert reset_n=0 asynchronously mid-window: all outputs are 0 immediately, and no window_done occurs until 100 samples after release.
